// File: rtl/peri_pwm_pkg.sv
// Shared definitions for the PWM dead-time stage: FSM states, register map and bit positions.
package peri_pwm_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        LO_ON   = 3'd1,
        DT_RISE = 3'd2,
        HI_ON   = 3'd3,
        DT_FALL = 3'd4
    } state_t;

    localparam logic [1:0] ADR_DEADTIME = 2'd0;
    localparam logic [1:0] ADR_CTRL     = 2'd1;
    localparam logic [1:0] ADR_STATUS   = 2'd2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_LO_POL = 1;

    localparam int ST_HI    = 0;
    localparam int ST_LO    = 1;
    localparam int ST_FAULT = 2;

endpackage

// File: rtl/peri_pwm_deadtime.sv
// Complementary hi/lo drive with programmable dead time, configured over an 8-bit Wishbone slave.
// Define PWM_DEADTIME_FAULT_EN to add the fault_i input and the STATUS fault latch.
module peri_pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wb_we_i,
    input  logic [3:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       pwm_i,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic       fault_i,
`endif
    output logic       hi_o,
    output logic       lo_o
);
    import peri_pwm_pkg::*;

    logic [DT_W-1:0] deadtime;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_n;
    logic            en;
    logic            lo_pol;
    logic            lo;
    logic            fault;
    logic            halt;
    logic            bus_wr;
    logic            dt_zero;
    logic [1:0]      adr;
    logic            unused_adr;
    state_t          state;
    state_t          nxt;

    assign adr        = wb_adr_i[1:0];
    assign unused_adr = ^wb_adr_i[3:2];
    assign bus_wr     = wb_stb_i & wb_we_i;
    assign wb_ack_o   = wb_stb_i;
    assign dt_zero    = (deadtime == '0);
    assign lo_o       = lo ^ lo_pol;

`ifdef PWM_DEADTIME_FAULT_EN
    // A fault arriving in the same cycle as a clear write keeps the latch set.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            fault <= 1'b0;
        else if (fault_i)
            fault <= 1'b1;
        else if (bus_wr && adr == ADR_STATUS && wb_dat_i[ST_FAULT])
            fault <= 1'b0;
    end
    assign halt = ~en | fault | fault_i;
`else
    assign fault = 1'b0;
    assign halt  = ~en;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deadtime <= '0;
            en       <= 1'b0;
            lo_pol   <= 1'b0;
        end else if (bus_wr) begin
            case (adr)
                ADR_DEADTIME: deadtime <= DT_W'(wb_dat_i);
                ADR_CTRL: begin
                    en     <= wb_dat_i[CTRL_EN];
                    lo_pol <= wb_dat_i[CTRL_LO_POL];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wb_dat_o = '0;
        if (wb_stb_i) begin
            case (adr)
                ADR_DEADTIME: wb_dat_o = 8'(deadtime);
                ADR_CTRL:     wb_dat_o = {6'b0, lo_pol, en};
                ADR_STATUS:   wb_dat_o = {5'b0, fault, lo, hi_o};
                default:      wb_dat_o = '0;
            endcase
        end
    end

    // Entering a gap loads DEADTIME; a zero dead time jumps straight to the other side.
    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        if (halt) begin
            nxt   = OFF;
            cnt_n = '0;
        end else begin
            case (state)
                OFF: begin
                    cnt_n = deadtime;
                    if (pwm_i) nxt = dt_zero ? HI_ON : DT_RISE;
                    else       nxt = dt_zero ? LO_ON : DT_FALL;
                end
                LO_ON: if (pwm_i) begin
                    nxt   = dt_zero ? HI_ON : DT_RISE;
                    cnt_n = deadtime;
                end
                HI_ON: if (!pwm_i) begin
                    nxt   = dt_zero ? LO_ON : DT_FALL;
                    cnt_n = deadtime;
                end
                DT_RISE: begin
                    if (!pwm_i) begin
                        nxt   = LO_ON;
                        cnt_n = '0;
                    end else if (cnt <= DT_W'(1)) begin
                        nxt   = HI_ON;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt - DT_W'(1);
                    end
                end
                DT_FALL: begin
                    if (pwm_i) begin
                        nxt   = HI_ON;
                        cnt_n = '0;
                    end else if (cnt <= DT_W'(1)) begin
                        nxt   = LO_ON;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt - DT_W'(1);
                    end
                end
                default: begin
                    nxt   = OFF;
                    cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= OFF;
            cnt   <= '0;
            hi_o  <= 1'b0;
            lo    <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            hi_o  <= (nxt == HI_ON);
            lo    <= (nxt == LO_ON);
        end
    end

endmodule

// File: doc/peri_pwm_deadtime.md
Name: peri_pwm_deadtime

Overview:
- Downstream stage of a PWM channel. Consumes one raw PWM level (pwm_i) and produces a complementary high-side/low-side pair with programmable dead time.
- Both outputs are never high in the same cycle.
- Configured over the same 8-bit Wishbone B4 peripheral bus as the channel. Sits between the channel and the pads driving a half-bridge.

Parameters:
- DT_W, 8, width of dead-time register and counter (max dead time 2^DT_W-1 cycles).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- wb_we_i  in  1  write enable
- wb_adr_i  in  4  register address; only [1:0] decoded
- wb_dat_i  in  8  write data
- wb_stb_i  in  1  strobe
- wb_dat_o  out  8  read data
- wb_ack_o  out  1  acknowledge
- pwm_i  in  1  raw PWM level from upstream channel
- hi_o  out  1  high-side drive, registered
- lo_o  out  1  low-side drive, registered, polarity per CTRL.LO_POL
- fault_i  in  1  external fault; present only with PWM_DEADTIME_FAULT_EN

Behaviour:
- Bus: wb_ack_o = wb_stb_i, same cycle, no wait states.
- Bus reads: wb_dat_o is combinational readback of the addressed register; 0 for unmapped addresses or when stb=0.
- Registers:
  - 0x0 DEADTIME[DT_W-1:0], reset 0.
  - 0x1 CTRL: bit0 EN, bit1 LO_POL; reset 0.
  - 0x2 STATUS, read-only except fault clear: bit0 hi state, bit1 lo state (pre-polarity), bit2 fault latch.
- Writes take effect on the next clock edge. A new DEADTIME is used from the next dead-time entry; a dead time already in progress is not changed.
- FSM states: OFF, LO_ON, DT_RISE, HI_ON, DT_FALL. Reset -> OFF.
- In OFF:
  - Stay while EN=0.
  - When EN=1: pwm_i=1 -> DT_RISE, pwm_i=0 -> DT_FALL, loading the counter.
- In LO_ON, pwm_i=1 -> DT_RISE, counter loaded with DEADTIME.
- In DT_RISE:
  - Counter expires -> HI_ON.
  - pwm_i=0 before expiry -> LO_ON directly (hi was never on, so this is safe).
- In HI_ON, pwm_i=0 -> DT_FALL.
- DT_FALL is symmetric: expiry -> LO_ON; pwm_i=1 before expiry -> HI_ON.
- Dead-time length: both sides low for exactly DEADTIME cycles between one side falling and the other rising.
- DEADTIME=0: direct switch; hi falls and lo rises on the same edge.
- Outputs:
  - hi_o=1 only in HI_ON.
  - Internal lo=1 only in LO_ON.
  - lo_o = lo XOR LO_POL.
- Latency: pwm_i edge -> first output change = 1 cycle.
- EN=0 in any state: next cycle state=OFF, hi_o=0, internal lo=0, counter cleared.
- Reset mid-operation: all registers 0, state OFF, hi_o=0, lo_o=0 on the next edge.
- Reset values: hi_o=0, lo_o=0 (LO_POL resets to 0), wb_dat_o=0.
- Counter saturates; no wrap. A load when counter is nonzero reloads it.

Optional Feature:
- Macro: PWM_DEADTIME_FAULT_EN.
- Defined:
  - fault_i=1 sets STATUS.fault on the next edge and forces state OFF.
  - While the latch is set, hi_o=0 and internal lo=0, regardless of EN or pwm_i.
  - Writing 1 to STATUS bit2 clears the latch.
  - If fault_i and the clear write occur in the same cycle, set wins.
  - After clearing, the OFF entry rules apply (full dead time before either side is driven).
- Undefined: fault_i port absent, STATUS bit2 reads 0, writes to STATUS are ignored.

Decomposition:
- Shared package peri_pwm_pkg:
  - state enum (OFF, LO_ON, DT_RISE, HI_ON, DT_FALL);
  - register address constants (ADR_DEADTIME=0, ADR_CTRL=1, ADR_STATUS=2);
  - CTRL bit indices (CTRL_EN=0, CTRL_LO_POL=1);
  - STATUS bit indices.
- No sub-module. The FSM, counter and register file are small enough to stay in one module.

Test Plan:
- Reset, then DEADTIME=3, CTRL=1, pwm_i=0 -> both low 3 cycles after enable, then lo_o=1; hi_o stays 0.
- Then pwm_i 0->1 -> next cycle lo_o=0; hi_o=0 for exactly 3 cycles, then hi_o=1. pwm_i 1->0 -> symmetric, lo_o=1 after 3 low cycles.
- DEADTIME=5, pwm_i 1-cycle-high pulse during LO_ON -> hi_o never asserts; lo_o returns to 1 two cycles after the rise. Check every cycle: never hi_o=1 with lo=1.
- DEADTIME=0, pwm_i toggling every cycle -> hi_o = pwm_i delayed 1 cycle, lo = its inverse. CTRL=3 (LO_POL) -> lo_o equals hi_o, and STATUS bit1 is still the inverse of hi.
- Mid-HI_ON write CTRL=0 -> next cycle hi_o=0, lo_o=0. rst_i asserted mid-DT_RISE -> outputs 0, reads of 0x0 and 0x1 return 0.
- With PWM_DEADTIME_FAULT_EN: fault_i pulse in HI_ON -> hi_o=0 next cycle, STATUS reads 0x04. Write 0x04 to 0x2 -> latch clears, and outputs resume only after DEADTIME cycles.
